iter_term_ctrl: RTL

- Iteration-termination controller that directly feeds the `termination` input of `sys_control_unit`.
- Watches the system FSM state to count decoding iterations and accumulates per-group syndrome results from the parity-check stage.
- Asserts `termination` when the iteration limit is reached or, optionally, when the syndrome is all-zero.
- Holds `termination` until the system FSM acknowledges with `de_frame_start`, then re-arms for the next frame.

---
 rtl/dec_ctrl_pkg.sv | 28 ++
 rtl/syn_accum.sv | 50 +++++
 rtl/iter_term_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/dec_ctrl_pkg.sv
// Shared decoder-control definitions.
//   - System FSM state codes as driven on sys_control_unit's state output.
//   - Encoding of the iteration-termination FSM.
//   - Default iteration-counter width.
package dec_ctrl_pkg;

  localparam int unsigned ITER_W_DEFAULT = 4;

  // sys_control_unit state codes (4-bit)
  localparam logic [3:0] INIT_LOAD = 4'b0000;
  localparam logic [3:0] MEM_INIT  = 4'b0001;
  localparam logic [3:0] CNU_IN    = 4'b0010;
  localparam logic [3:0] CNU_PROC  = 4'b0011;
  localparam logic [3:0] CNU_OUT   = 4'b0100;
  localparam logic [3:0] P2P_C_OUT = 4'b0101;
  localparam logic [3:0] VNU_IN    = 4'b0110;
  localparam logic [3:0] VNU_PROC  = 4'b0111;
  localparam logic [3:0] VNU_OUT   = 4'b1000;
  localparam logic [3:0] P2P_V_OUT = 4'b1001;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StTerm = 2'b10,
    StAck  = 2'b11
  } term_state_e;

endpackage

// File: rtl/syn_accum.sv
// Per-iteration syndrome accumulator.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   clr_i          : restart accumulation (wins over same-cycle results)
//   en_i           : accept results this cycle
//   syn_valid_i    : one partial-syndrome result present
//   syn_zero_i     : that partial syndrome is all-zero
//   pass_o         : all SYN_GROUPS results seen and every one was zero,
//                    including a result arriving this cycle
module syn_accum #(
  parameter int unsigned SYN_GROUPS = 4,
  parameter int unsigned GRP_W      = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  input  logic syn_valid_i,
  input  logic syn_zero_i,
  output logic pass_o
);

  localparam logic [GRP_W-1:0] GrpMax = GRP_W'(SYN_GROUPS);
  localparam logic [GRP_W-1:0] GrpOne = GRP_W'(1);

  logic [GRP_W-1:0] grp_q, grp_d;
  logic             all_zero_q, all_zero_d;

  always_comb begin
    grp_d      = grp_q;
    all_zero_d = all_zero_q;
    if (en_i && syn_valid_i) begin
      // Saturate so extra results cannot wrap the count past the check value.
      if (grp_q != GrpMax) grp_d = grp_q + GrpOne;
      all_zero_d = all_zero_q & syn_zero_i;
    end
  end

  assign pass_o = (grp_d == GrpMax) && all_zero_d;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      grp_q      <= '0;
      all_zero_q <= 1'b1;
    end else begin
      grp_q      <= grp_d;
      all_zero_q <= all_zero_d;
    end
  end

endmodule

// File: rtl/iter_term_ctrl.sv
// Iteration-termination controller feeding sys_control_unit.termination.
// Counts decoding iterations (rising edge of sys_fsm_state == VNU_OUT_CODE) and
// raises termination at the iteration limit or, when ITER_TERM_EARLY_STOP_EN is
// defined, when every syndrome group of an iteration reports zero. termination
// is held until de_frame_start acknowledges it; the ACK cycle re-arms.
// Ports:
//   read_clk, rst    : clock, synchronous active-high reset
//   sys_fsm_state    : system FSM state
//   de_frame_start   : frame start / termination acknowledge
//   max_iter_cfg     : iteration limit, sampled at frame start (0 treated as 1)
//   syn_valid/zero   : partial-syndrome results
//   termination      : stop request to the system FSM
//   iter_cnt         : completed iterations in the current frame
//   early_stop       : last termination was syndrome-triggered
//   frame_done       : one-cycle pulse on acknowledge
//   busy             : frame in progress
module iter_term_ctrl
  import dec_ctrl_pkg::*;
#(
  parameter int unsigned ITER_W       = ITER_W_DEFAULT,
  parameter int unsigned SYN_GROUPS   = 4,
  parameter logic [3:0]  VNU_OUT_CODE = VNU_OUT,
  parameter int unsigned GRP_W        = 3
) (
  input  logic              read_clk,
  input  logic              rst,
  input  logic [3:0]        sys_fsm_state,
  input  logic              de_frame_start,
  input  logic [ITER_W-1:0] max_iter_cfg,
  input  logic              syn_valid,
  input  logic              syn_zero,
  output logic              termination,
  output logic [ITER_W-1:0] iter_cnt,
  output logic              early_stop,
  output logic              frame_done,
  output logic              busy
);

  localparam logic [ITER_W-1:0] IterMax = '1;
  localparam logic [ITER_W-1:0] IterOne = ITER_W'(1);

  term_state_e       state_q, state_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [ITER_W-1:0] max_q, max_d;
  logic              early_q, early_d;
  logic              vnu_q;
  logic              vnu_match, boundary;
  logic [ITER_W:0]   iter_inc;
  logic              acc_clr;
  logic              syn_pass;

  assign vnu_match = (sys_fsm_state == VNU_OUT_CODE);
  assign boundary  = vnu_match & ~vnu_q;
  // One bit wider so the limit compare cannot wrap at the top count.
  assign iter_inc  = {1'b0, iter_q} + {{ITER_W{1'b0}}, 1'b1};

`ifdef ITER_TERM_EARLY_STOP_EN
  syn_accum #(
    .SYN_GROUPS(SYN_GROUPS),
    .GRP_W     (GRP_W)
  ) u_syn_accum (
    .clk_i      (read_clk),
    .rst_i      (rst),
    .clr_i      (acc_clr),
    .en_i       (state_q == StRun),
    .syn_valid_i(syn_valid),
    .syn_zero_i (syn_zero),
    .pass_o     (syn_pass)
  );
`else
  logic unused_syn;
  assign unused_syn = ^{syn_valid, syn_zero, acc_clr};
  assign syn_pass   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    max_d   = max_q;
    early_d = early_q;
    acc_clr = 1'b0;

    unique case (state_q)
      StIdle: if (de_frame_start) state_d = StRun;
      StRun: begin
        if (boundary) begin
          if (iter_q != IterMax) iter_d = iter_inc[ITER_W-1:0];
          if (syn_pass) begin
            state_d = StTerm;
            early_d = 1'b1;
          end else if (iter_inc >= {1'b0, max_q}) begin
            state_d = StTerm;
          end else begin
            acc_clr = 1'b1;
          end
        end
      end
      StTerm: if (de_frame_start) state_d = StAck;
      StAck:  state_d = de_frame_start ? StRun : StIdle;
      default: state_d = StIdle;
    endcase

    // Frame start, from IDLE or directly out of the acknowledge cycle.
    if ((state_q == StIdle || state_q == StAck) && de_frame_start) begin
      max_d   = (max_iter_cfg == '0) ? IterOne : max_iter_cfg;
      iter_d  = '0;
      early_d = 1'b0;
      acc_clr = 1'b1;
    end
  end

  always_ff @(posedge read_clk) begin
    if (rst) begin
      state_q <= StIdle;
      iter_q  <= '0;
      max_q   <= '0;
      early_q <= 1'b0;
      vnu_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      max_q   <= max_d;
      early_q <= early_d;
      vnu_q   <= vnu_match;
    end
  end

  assign termination = (state_q == StTerm);
  assign frame_done  = (state_q == StAck);
  assign busy        = (state_q == StRun) || (state_q == StTerm);
  assign iter_cnt    = iter_q;
  assign early_stop  = early_q;

endmodule
